// File: rtl/prog_loader.sv
// Boot-time program loader: parses A5/len_hi/len_lo/payload/checksum frames and writes the payload to program memory.
// Latency: a payload byte accepted on edge N appears as a registered mem_we pulse after edge N; status changes on the CSUM edge.
// Backpressure: in_ready follows mem_ready while in DATA, is 1 in every other state and is 0 while rst is high.
module prog_loader #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [DATA_W-1:0] SYNC = DATA_W'(8'hA5);

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       count;
  logic [DATA_W-1:0] csum;
  logic              accept;

  assign accept = in_valid & in_ready;

  // Ready depends only on state: a DATA byte is taken only when memory can absorb its write.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == DATA) ? mem_ready : 1'b1;
    end
  end

  // Frame parser with registered memory-write and cpu/status outputs; advances only on accepted bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      count     <= '0;
      csum      <= '0;
      mem_addr  <= START_ADDR;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == SYNC) state <= LEN_HI;
          end
          LEN_HI: begin
            len[15:8] <= in_data[7:0];
            state     <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= in_data[7:0];
            count    <= '0;
            csum     <= '0;
            state    <= ({len[15:8], in_data[7:0]} == 16'd0) ? CSUM : DATA;
          end
          DATA: begin
            mem_wdata <= in_data;
            // Address arithmetic is modulo 2^ADDR_W so a load may wrap past the top of memory.
            mem_addr  <= START_ADDR + ADDR_W'(count);
            mem_we    <= 1'b1;
            csum      <= csum + in_data;
            count     <= count + 16'd1;
            if (count + 16'd1 == len) state <= CSUM;
          end
          CSUM: begin
            if (in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              err     <= 1'b0;
              cpu_rst <= 1'b0;
            end else begin
              state   <= ERR;
              done    <= 1'b0;
              err     <= 1'b1;
              cpu_rst <= 1'b1;
            end
          end
          DONE: begin
            // A new sync byte re-arms the loader and puts the cpu back into reset.
            if (in_data == SYNC) begin
              state   <= LEN_HI;
              cpu_rst <= 1'b1;
              done    <= 1'b0;
            end
          end
          ERR: begin
            if (in_data == SYNC) begin
              state <= LEN_HI;
              err   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances share stimulus, one at START_ADDR 0000 and one at FFFE.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Writes from each instance are captured into queues and checked per scenario.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        mem_ready = 1'b1;

  logic        in_ready_a, mem_we_a, cpu_rst_a, done_a, err_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_wdata_a;
  logic        in_ready_b, mem_we_b, cpu_rst_b, done_b, err_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  mem_wdata_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [23:0] wq_a[$];
  logic [23:0] wq_b[$];
  int          wc_a[$];

  prog_loader #(.ADDR_W(16), .DATA_W(8), .START_ADDR(16'h0000)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .mem_ready(mem_ready), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a)
  );

  prog_loader #(.ADDR_W(16), .DATA_W(8), .START_ADDR(16'hFFFE)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .mem_ready(mem_ready), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe of both instances.
  always @(negedge clk) begin
    if (mem_we_a) begin
      wq_a.push_back({mem_addr_a, mem_wdata_a});
      wc_a.push_back(cyc);
    end
    if (mem_we_b) wq_b.push_back({mem_addr_b, mem_wdata_b});
  end

  task automatic clear_q();
    wq_a.delete();
    wq_b.delete();
    wc_a.delete();
  endtask

  // Presents one byte and returns on the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      #4;
      r = in_ready_a;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!r) begin
      $display("FAIL send_byte timeout: byte=%h in_ready never high in %0d cycles", b, n);
      bad++;
      total++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_a); end
    total++; if (mem_addr_a !== 16'h0000) begin bad++; $display("FAIL rst_addr_a got=%h exp=0000", mem_addr_a); end
    total++; if (mem_addr_b !== 16'hFFFE) begin bad++; $display("FAIL rst_addr_b got=%h exp=fffe", mem_addr_b); end
    total++; if (mem_wdata_a !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h exp=00", mem_wdata_a); end
    total++; if (mem_we_a !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we_a); end
    total++; if ({cpu_rst_a, done_a, err_a} !== 3'b100) begin bad++; $display("FAIL rst_status got=%b exp=100", {cpu_rst_a, done_a, err_a}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready_a); end
  endtask

  task automatic test_basic();
    logic [7:0] fr[7];
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    clear_q();
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    total++; if ({cpu_rst_a, done_a} !== 2'b10) begin bad++; $display("FAIL basic_pre_csum got=%b exp=10", {cpu_rst_a, done_a}); end
    send_byte(fr[6]);
    total++; if ({cpu_rst_a, done_a, err_a} !== 3'b010) begin bad++; $display("FAIL basic_status got=%b exp=010", {cpu_rst_a, done_a, err_a}); end
    repeat (2) @(negedge clk);
    total++; if (wq_a.size() !== 3) begin bad++; $display("FAIL basic_nwrites got=%0d exp=3", wq_a.size()); end
    if (wq_a.size() == 3) begin
      total++; if (wq_a[0] !== 24'h0000_11) begin bad++; $display("FAIL basic_w0 got=%h exp=000011", wq_a[0]); end
      total++; if (wq_a[1] !== 24'h0001_22) begin bad++; $display("FAIL basic_w1 got=%h exp=000122", wq_a[1]); end
      total++; if (wq_a[2] !== 24'h0002_33) begin bad++; $display("FAIL basic_w2 got=%h exp=000233", wq_a[2]); end
      total++; if (wc_a[2] - wc_a[0] !== 2) begin bad++; $display("FAIL basic_b2b cycle span got=%0d exp=2", wc_a[2] - wc_a[0]); end
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] fr[6];
    fr = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
    clear_q();
    send_byte(fr[0]);
    total++; if ({cpu_rst_a, done_a} !== 2'b10) begin bad++; $display("FAIL rearm_done got=%b exp=10", {cpu_rst_a, done_a}); end
    for (int i = 1; i < 6; i++) send_byte(fr[i]);
    repeat (2) @(negedge clk);
    total++; if ({cpu_rst_a, done_a, err_a} !== 3'b101) begin bad++; $display("FAIL bad_status got=%b exp=101", {cpu_rst_a, done_a, err_a}); end
    total++; if (wq_a.size() !== 2) begin bad++; $display("FAIL bad_nwrites got=%0d exp=2", wq_a.size()); end
    if (wq_a.size() == 2) begin
      total++; if (wq_a[1] !== 24'h0001_20) begin bad++; $display("FAIL bad_w1 got=%h exp=000120", wq_a[1]); end
    end
    clear_q();
    send_byte(8'hA5);
    total++; if ({cpu_rst_a, err_a} !== 2'b10) begin bad++; $display("FAIL rearm_err got=%b exp=10", {cpu_rst_a, err_a}); end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    total++; if ({cpu_rst_a, done_a, err_a} !== 3'b010) begin bad++; $display("FAIL zero_len_status got=%b exp=010", {cpu_rst_a, done_a, err_a}); end
    total++; if (wq_a.size() !== 0) begin bad++; $display("FAIL zero_len_nwrites got=%0d exp=0", wq_a.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] fr[8];
    fr = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    clear_q();
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    in_data = fr[5];
    in_valid = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready_a); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    for (int i = 5; i < 8; i++) send_byte(fr[i]);
    repeat (2) @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done_a); end
    total++; if (wq_a.size() !== 4) begin bad++; $display("FAIL bp_nwrites got=%0d exp=4", wq_a.size()); end
    if (wq_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wq_a[i] !== {16'(i), 8'(i + 1)}) begin
          bad++; $display("FAIL bp_w%0d got=%h exp=%h", i, wq_a[i], {16'(i), 8'(i + 1)});
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] garb[3];
    logic [7:0] fr[6];
    garb = '{8'h00, 8'hFF, 8'h5A};
    fr = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < 3; i++) send_byte(garb[i]);
    repeat (2) @(negedge clk);
    total++; if (wq_a.size() !== 0) begin bad++; $display("FAIL garbage_nwrites got=%0d exp=0", wq_a.size()); end
    total++; if ({cpu_rst_a, done_a} !== 2'b10) begin bad++; $display("FAIL garbage_status got=%b exp=10", {cpu_rst_a, done_a}); end
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i]);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    total++; if ({cpu_rst_a, done_a, err_a} !== 3'b010) begin bad++; $display("FAIL gaps_status got=%b exp=010", {cpu_rst_a, done_a, err_a}); end
    total++; if (wq_a.size() !== 2) begin bad++; $display("FAIL gaps_nwrites got=%0d exp=2", wq_a.size()); end
    if (wq_a.size() == 2) begin
      total++; if (wq_a[0] !== 24'h0000_AA) begin bad++; $display("FAIL gaps_w0 got=%h exp=0000aa", wq_a[0]); end
      total++; if (wq_a[1] !== 24'h0001_55) begin bad++; $display("FAIL gaps_w1 got=%h exp=000155", wq_a[1]); end
    end
  endtask

  task automatic test_wrap_reset();
    logic [7:0] fr[7];
    logic [7:0] fr2[5];
    fr = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    fr2 = '{8'hA5, 8'h00, 8'h01, 8'h42, 8'h42};
    clear_q();
    for (int i = 0; i < 7; i++) send_byte(fr[i]);
    repeat (2) @(negedge clk);
    total++; if (wq_b.size() !== 3) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=3", wq_b.size()); end
    if (wq_b.size() == 3) begin
      total++; if (wq_b[0] !== 24'hFFFE_01) begin bad++; $display("FAIL wrap_w0 got=%h exp=fffe01", wq_b[0]); end
      total++; if (wq_b[1] !== 24'hFFFF_02) begin bad++; $display("FAIL wrap_w1 got=%h exp=ffff02", wq_b[1]); end
      total++; if (wq_b[2] !== 24'h0000_03) begin bad++; $display("FAIL wrap_w2 got=%h exp=000003", wq_b[2]); end
    end
    total++; if (done_b !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", done_b); end
    // Abort a frame after its first payload byte.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h07);
    rst = 1'b1;
    in_data = 8'h08;
    in_valid = 1'b1;
    @(negedge clk);
    clear_q();
    #4;
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready_a); end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wq_a.size() + wq_b.size() !== 0) begin bad++; $display("FAIL midrst_nwrites got=%0d exp=0", wq_a.size() + wq_b.size()); end
    total++; if ({cpu_rst_b, done_b, err_b} !== 3'b100) begin bad++; $display("FAIL midrst_status got=%b exp=100", {cpu_rst_b, done_b, err_b}); end
    total++; if (mem_addr_b !== 16'hFFFE) begin bad++; $display("FAIL midrst_addr got=%h exp=fffe", mem_addr_b); end
    for (int i = 0; i < 5; i++) send_byte(fr2[i]);
    repeat (2) @(negedge clk);
    total++; if ({cpu_rst_b, done_b, err_b} !== 3'b010) begin bad++; $display("FAIL reload_status got=%b exp=010", {cpu_rst_b, done_b, err_b}); end
    total++; if (wq_b.size() !== 1 || wq_b[0] !== 24'hFFFE_42) begin bad++; $display("FAIL reload_write got n=%0d first=%h exp n=1 fffe42", wq_b.size(), (wq_b.size() > 0) ? wq_b[0] : 24'h0); end
    total++; if (wq_a.size() !== 1 || wq_a[0] !== 24'h0000_42) begin bad++; $display("FAIL reload_write_a got n=%0d first=%h exp n=1 000042", wq_a.size(), (wq_a.size() > 0) ? wq_a[0] : 24'h0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_backpressure();
    test_gaps();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the cpu.
- Receives a framed byte stream on a valid/ready interface and writes the payload sequentially into program memory.
- Holds the cpu in reset while a load is in progress and releases it only after the frame checksum is verified.
- Fixed frame format: sync 0xA5, length high byte, length low byte, N payload bytes, checksum byte.

Parameters:
ADDR_W, 16, width of the memory address output; matches the cpu addr_bus.
DATA_W, 8, width of the stream and memory data; matches the cpu data_bus.
START_ADDR, 16'h0000, memory address written by the first payload byte.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
in_data  input  DATA_W  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts in_data this cycle. A byte transfers when in_valid and in_ready are both high.
mem_ready  input  1  memory can take a write this cycle.
mem_addr  output  ADDR_W  write address (registered).
mem_wdata  output  DATA_W  write data (registered).
mem_we  output  1  one-cycle write strobe (registered).
cpu_rst  output  1  reset to the cpu; high while loading or errored.
done  output  1  last frame loaded with a correct checksum.
err  output  1  last frame failed its checksum.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_addr START_ADDR, mem_wdata 0, mem_we 0, cpu_rst 1, done 0, err 0, length and byte counters 0, checksum accumulator 0.
- Reset asserted in any state, including mid-frame, aborts the frame. No mem_we is issued in the reset cycle or after it.
- in_ready is combinational from state:
  - 0 while rst is high.
  - equal to mem_ready in DATA.
  - 1 in every other state.
- States and transitions, evaluated on an accepted byte only:
  - IDLE: 0xA5 -> LEN_HI. Any other byte is discarded.
  - LEN_HI: latch the byte as len[15:8] -> LEN_LO.
  - LEN_LO: latch the byte as len[7:0]. Clear the counter and checksum. If len==0 go to CSUM, else go to DATA.
  - DATA: mem_wdata<=byte; mem_addr<=START_ADDR+count (mod 2^ADDR_W); mem_we<=1 on the next edge. checksum+=byte (mod 256); count+=1. When count reaches len, go to CSUM.
  - CSUM: if byte==checksum go to DONE (done 1, err 0). Otherwise go to ERR (err 1, done 0).
  - DONE: cpu_rst 0. 0xA5 re-arms: go to LEN_HI, cpu_rst 1, done 0. Other bytes are discarded.
  - ERR: cpu_rst stays 1. 0xA5 re-arms: go to LEN_HI, err 0. Other bytes are discarded.
- Timing of cpu_rst, done and err:
  - cpu_rst is 1 in IDLE, LEN_HI, LEN_LO, DATA, CSUM and ERR.
  - cpu_rst falls on the same edge the FSM enters DONE.
  - done and err change on the edge that leaves CSUM or on the re-arm edge.
- mem_we timing:
  - mem_we is high for exactly one cycle per payload byte, the cycle after acceptance.
  - It is 0 in every other cycle.
  - Back-to-back accepted bytes give consecutive mem_we pulses with incrementing mem_addr.
- mem_ready low in DATA stalls acceptance. There is no loss and no duplicate write.
- in_valid low in any state means hold: no state change, no write.
- Address wrap: with START_ADDR+count past 2^ADDR_W-1, the address wraps to 0.
- The length counter is 16 bits. len=65535 is legal.

Test Plan:
- Basic load: reset 2 cycles, then send A5 00 03 11 22 33 66. Expect mem_we pulses at addresses 0000/0001/0002 with data 11/22/33, then done=1, err=0, and cpu_rst falling one cycle after the checksum byte.
- Bad checksum: send A5 00 02 10 20 31. Expect 2 writes, err=1, done=0, cpu_rst held at 1. Then send A5 00 00 00: expect err cleared, done=1, cpu_rst=0, no writes.
- Backpressure: during the payload of A5 00 04 01 02 03 04 0A, hold mem_ready low for 3 cycles mid-payload. Expect in_ready low for those cycles, exactly 4 writes with data 01..04 in order, and done=1.
- Sync hunting and gaps: send garbage 00 FF 5A, then a valid frame with in_valid toggling every other cycle. Expect the garbage ignored, no writes before A5, and a correct load.
- Wrap and reset mid-frame: with START_ADDR=16'hFFFE, send a 3-byte payload. Expect writes at FFFE, FFFF, 0000. Then send a new frame and assert rst after 1 payload byte. Expect no further mem_we, cpu_rst=1, state IDLE, and a subsequent good frame loading normally.
